// File: rtl/sdrx_pkg.sv
// ============================================================================
// Module   : sdrx_pkg
// Brief    : Shared encodings, state enum and helpers for the SDIO receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdrx_pkg;

    localparam logic [1:0] WIDTH_1 = 2'd0;
    localparam logic [1:0] WIDTH_4 = 2'd1;
    localparam logic [1:0] WIDTH_8 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_END  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_END     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    function automatic logic [7:0] lane_mask(input logic [1:0] width);
        case (width)
            WIDTH_1: lane_mask = 8'h01;
            WIDTH_4: lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    endfunction

    // Strobes per 32-bit word, minus one, so it compares directly with the bit counter.
    function automatic logic [4:0] strobes_per_word_m1(input logic [1:0] width);
        case (width)
            WIDTH_1: strobes_per_word_m1 = 5'd31;
            WIDTH_4: strobes_per_word_m1 = 5'd7;
            default: strobes_per_word_m1 = 5'd3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdcrc16_lane.sv
// ============================================================================
// Module   : sdcrc16_lane
// Brief    : Serial CRC16 for one data lane; step folds a bit in, shift drains it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdcrc16_lane
    import sdrx_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic step_i,
    input  logic shift_i,
    input  logic bit_i,
    output logic msb_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = 16'h0000;
        end else if (step_i) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_i) ? CRC16_POLY : 16'h0000);
        end else if (shift_i) begin
            crc_d = {crc_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign msb_o = crc_q[15];

endmodule

`default_nettype wire

// File: rtl/sdrxframe.sv
// ============================================================================
// Module   : sdrxframe
// Brief    : SDR SDIO data-block receiver: start bit, data, per-lane CRC16, end bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdrxframe
    import sdrx_pkg::*;
#(
    parameter int LGLEN     = 10,
    parameter int LGTIMEOUT = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic [1:0]           i_width,
    input  logic [LGLEN-1:0]     i_length,
    input  logic [LGTIMEOUT-1:0] i_timeout,
    input  logic                 i_rx_strb,
    input  logic [7:0]           i_rx_data,
    output logic                 o_valid,
    output logic [31:0]          o_data,
    output logic                 o_last,
    output logic                 o_done,
    output logic                 o_err,
    output logic [1:0]           o_errcode
);

    state_t               state_q;
    logic [31:0]          sr_q;
    logic [31:0]          sr_d;
    logic [4:0]           bcnt_q;
    logic [LGLEN-3:0]     wcnt_q;
    logic [LGLEN-3:0]     wcnt_d;
    logic [3:0]           ccnt_q;
    logic [LGTIMEOUT-1:0] tcnt_q;
    logic [LGTIMEOUT-1:0] tcnt_d;
    logic                 mism_q;
    logic                 valid_q;
    logic [31:0]          data_q;
    logic                 last_q;
    logic                 done_q;
    logic                 err_q;
    logic [1:0]           errcode_q;

    logic [7:0]           lane_act;
    logic [4:0]           spw_m1;
    logic [LGLEN-3:0]     nwords;
    logic [7:0]           crc_msb;
    logic                 crc_clear;
    logic                 crc_step;
    logic                 crc_shift;
    logic                 crc_bad;
    logic                 end_bad;
    logic                 unused_len;

    assign lane_act   = lane_mask(i_width);
    assign spw_m1     = strobes_per_word_m1(i_width);
    assign nwords     = i_length[LGLEN-1:2];
    assign unused_len = ^i_length[1:0];

    assign wcnt_d = wcnt_q + (LGLEN-2)'(1);
    assign tcnt_d = (&tcnt_q) ? tcnt_q : tcnt_q + LGTIMEOUT'(1);

    always_comb begin
        case (i_width)
            WIDTH_1: sr_d = {sr_q[30:0], i_rx_data[0]};
            WIDTH_4: sr_d = {sr_q[27:0], i_rx_data[3:0]};
            default: sr_d = {sr_q[23:0], i_rx_data};
        endcase
    end

    // CRCs stay cleared until the start bit, so every block begins from zero.
    assign crc_clear = !i_en || (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign crc_step  = i_en && i_rx_strb && (state_q == ST_DATA);
    assign crc_shift = i_en && i_rx_strb && (state_q == ST_CRC);
    assign crc_bad   = |((i_rx_data ^ crc_msb) & lane_act);
    assign end_bad   = |(~i_rx_data & lane_act);

    for (genvar k = 0; k < 8; k++) begin : g_lane
        sdcrc16_lane u_crc (
            .clk_i   (i_clk),
            .rst_ni  (i_reset_n),
            .clear_i (crc_clear || !lane_act[k]),
            .step_i  (crc_step),
            .shift_i (crc_shift),
            .bit_i   (i_rx_data[k]),
            .msb_o   (crc_msb[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= 32'h0;
            bcnt_q    <= 5'd0;
            wcnt_q    <= '0;
            ccnt_q    <= 4'd0;
            tcnt_q    <= '0;
            mism_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 32'h0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= ERR_NONE;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            if (!i_en) begin
                state_q <= ST_IDLE;
                bcnt_q  <= 5'd0;
                wcnt_q  <= '0;
                ccnt_q  <= 4'd0;
                tcnt_q  <= '0;
                mism_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_WAIT;
                        tcnt_q    <= '0;
                        err_q     <= 1'b0;
                        errcode_q <= ERR_NONE;
                    end
                    ST_WAIT: begin
                        if (i_rx_strb) begin
                            if (!i_rx_data[0]) begin
                                bcnt_q  <= 5'd0;
                                wcnt_q  <= '0;
                                ccnt_q  <= 4'd0;
                                mism_q  <= 1'b0;
                                state_q <= (nwords == '0) ? ST_CRC : ST_DATA;
                            end else begin
                                tcnt_q <= tcnt_d;
                                if (tcnt_d >= i_timeout) begin
                                    err_q     <= 1'b1;
                                    errcode_q <= ERR_TIMEOUT;
                                    done_q    <= 1'b1;
                                    state_q   <= ST_DONE;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (i_rx_strb) begin
                            sr_q <= sr_d;
                            if (bcnt_q == spw_m1) begin
                                bcnt_q  <= 5'd0;
                                valid_q <= 1'b1;
                                data_q  <= sr_d;
                                wcnt_q  <= wcnt_d;
                                if (wcnt_d == nwords) begin
                                    last_q  <= 1'b1;
                                    state_q <= ST_CRC;
                                end
                            end else begin
                                bcnt_q <= bcnt_q + 5'd1;
                            end
                        end
                    end
                    ST_CRC: begin
                        if (i_rx_strb) begin
                            if (crc_bad) begin
                                mism_q <= 1'b1;
                            end
                            ccnt_q <= ccnt_q + 4'd1;
                            if (ccnt_q == 4'd15) begin
                                state_q <= ST_END;
                            end
                        end
                    end
                    ST_END: begin
                        if (i_rx_strb) begin
                            // A CRC mismatch outranks a bad end bit.
                            err_q     <= mism_q || end_bad;
                            errcode_q <= mism_q ? ERR_CRC : (end_bad ? ERR_END : ERR_NONE);
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_q   <= ST_WAIT;
                        tcnt_q    <= '0;
                        err_q     <= 1'b0;
                        errcode_q <= ERR_NONE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_last    = last_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_errcode = errcode_q;

endmodule

`default_nettype wire
